// File: rtl/jtl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtl_pkg
// Description : Shared defaults, parameter limits, freeze-mode constants and
//               a counter-width helper for the JTL pulse chain.
// Revision    : 1.0 - initial release
// ============================================================================
package jtl_pkg;

    // Parameter defaults
    localparam int c_CHANNELS_DEF = 4;
    localparam int c_DELAY_DEF    = 4;
    localparam int c_CT_DEF       = 5;
    localparam int c_STARTUP_DEF  = 4;
    localparam int c_CNT_W_DEF    = 8;

    // Parameter limits
    localparam int c_CHANNELS_MAX = 32;
    localparam int c_DELAY_MAX    = 64;
    localparam int c_CT_MAX       = 64;

    // Violation handling modes
    localparam int MODE_DROP   = 0;
    localparam int MODE_FREEZE = 1;
    localparam int c_FREEZE_DEF = MODE_DROP;

    // Wide enough to hold a per-cycle violation count for c_CHANNELS_MAX channels
    localparam int c_NVIOL_W = 6;

    // Bits needed to hold values 0..max_value, never less than one
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtl_chan.sv
`default_nettype none
// ============================================================================
// Module      : jtl_chan
// Description : One pulse channel: edge detect, critical-timing window,
//               fixed-latency toggle pipeline, sticky error and optional
//               freeze on violation.
// Revision    : 1.0 - initial release
// ============================================================================
module jtl_chan
    import jtl_pkg::*;
#(
    parameter int DELAY  = c_DELAY_DEF,
    parameter int CT     = c_CT_DEF,
    parameter int FREEZE = c_FREEZE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic ev_en,
    input  logic err_clr,
    output logic q,
    output logic err,
    output logic viol
);

    localparam int                c_WC_W      = cnt_width(CT - 1);
    localparam logic [c_WC_W-1:0] c_WC_LOAD   = c_WC_W'(CT - 1);
    localparam bit                c_DO_FREEZE = (FREEZE == MODE_FREEZE);

    logic              r_a_d;
    logic [c_WC_W-1:0] r_wc;
    logic [DELAY-1:0]  r_pipe;
    logic              r_q;
    logic              r_err;
    logic              r_frozen;

    logic w_event;
    logic w_live;
    logic w_accept;
    logic w_viol;
    logic w_flush;

    // Classify this cycle's event: ignored, accepted or a window violation
    always_comb begin
        w_event  = a ^ r_a_d;
        w_live   = w_event & ev_en & ~r_frozen;
        w_accept = w_live & (r_wc == '0);
        w_viol   = w_live & (r_wc != '0);
        w_flush  = w_viol & c_DO_FREEZE;
    end

    // Previous input level; loaded from a in reset so release creates no event
    always_ff @(posedge clk) begin
        r_a_d <= a;
    end

    // Critical-timing window: armed only by accepted events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wc <= '0;
        end else if (w_accept) begin
            r_wc <= c_WC_LOAD;
        end else if (r_wc != '0) begin
            r_wc <= r_wc - 1'b1;
        end
    end

    // Toggle-request shift register; one bit per accepted event in flight
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_accept;
            for (int j = 1; j < DELAY; j++) begin
                r_pipe[j] <= r_pipe[j-1];
            end
        end
    end

    // Output toggles when a request leaves the pipe; a flush holds the level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (!w_flush) begin
            r_q <= r_q ^ r_pipe[DELAY-1];
        end
    end

    // Sticky error and freeze: clear first, then a same-cycle violation sets
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err    <= 1'b0;
            r_frozen <= 1'b0;
        end else begin
            r_err    <= (r_err & ~err_clr) | w_viol;
            r_frozen <= (r_frozen & ~err_clr) | w_flush;
        end
    end

    assign q    = r_q;
    assign err  = r_err;
    assign viol = w_viol;

endmodule
`default_nettype wire

// File: rtl/thmitll_jtl_chain.sv
`default_nettype none
// ============================================================================
// Module      : thmitll_jtl_chain
// Description : Multi-channel JTL pulse chain with fixed propagation delay,
//               critical-timing checking, startup blanking and a shared
//               saturating violation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module thmitll_jtl_chain
    import jtl_pkg::*;
#(
    parameter int CHANNELS = c_CHANNELS_DEF,
    parameter int DELAY    = c_DELAY_DEF,
    parameter int CT       = c_CT_DEF,
    parameter int STARTUP  = c_STARTUP_DEF,
    parameter int FREEZE   = c_FREEZE_DEF,
    parameter int CNT_W    = c_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a,
    input  logic                err_clr,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] err,
    output logic [CNT_W-1:0]    viol_cnt
);

    localparam int                 c_SU_W    = cnt_width(STARTUP);
    localparam logic [c_SU_W-1:0]  c_SU_LOAD = c_SU_W'(STARTUP);
    localparam int                 c_SUM_W   = CNT_W + c_NVIOL_W + 1;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = {{(c_SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [c_SU_W-1:0]    r_su_cnt;
    logic [CNT_W-1:0]     r_viol_cnt;

    logic                 w_ev_en;
    logic [CHANNELS-1:0]  w_viol;
    logic [c_NVIOL_W-1:0] w_nviol;
    logic [c_SUM_W-1:0]   w_base;
    logic [c_SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]     w_cnt_next;

    // Startup blanking counter; events are ignored while it is nonzero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_su_cnt <= c_SU_LOAD;
        end else if (r_su_cnt != '0) begin
            r_su_cnt <= r_su_cnt - 1'b1;
        end
    end

    assign w_ev_en = (r_su_cnt == '0);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            jtl_chan #(
                .DELAY  (DELAY),
                .CT     (CT),
                .FREEZE (FREEZE)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .a       (a[i]),
                .ev_en   (w_ev_en),
                .err_clr (err_clr),
                .q       (q[i]),
                .err     (err[i]),
                .viol    (w_viol[i])
            );
        end
    endgenerate

    // Count this cycle's violations onto the (possibly cleared) total, saturating
    always_comb begin
        w_nviol = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_nviol = w_nviol + c_NVIOL_W'(w_viol[k]);
        end
        w_base     = err_clr ? '0 : {{(c_SUM_W-CNT_W){1'b0}}, r_viol_cnt};
        w_sum      = w_base + {{(c_SUM_W-c_NVIOL_W){1'b0}}, w_nviol};
        w_cnt_next = (w_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    // Shared violation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_viol_cnt <= '0;
        end else begin
            r_viol_cnt <= w_cnt_next;
        end
    end

    assign viol_cnt = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_thmitll_jtl_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_thmitll_jtl_chain
// Description : Directed self-checking bench. Four instances cover defaults,
//               freeze mode, a 2-bit counter and CT=1 back-to-back traffic.
//               Edge 0 is the last reset edge; inputs change 1 time unit
//               after an edge and outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thmitll_jtl_chain;

    logic       clk;
    logic       rst;
    logic       err_clr;
    logic [3:0] a0, a1, a2, a3;
    logic [3:0] q0, q1, q2, q3;
    logic [3:0] err0, err1, err2, err3;
    logic [7:0] vc0, vc1, vc3;
    logic [1:0] vc2;

    int tests_run;
    int tests_failed;
    int e;

    // Defaults
    thmitll_jtl_chain u_dut0 (
        .clk(clk), .rst(rst), .a(a0), .err_clr(err_clr),
        .q(q0), .err(err0), .viol_cnt(vc0)
    );

    // Freeze mode
    thmitll_jtl_chain #(.FREEZE(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .err_clr(err_clr),
        .q(q1), .err(err1), .viol_cnt(vc1)
    );

    // Narrow counter
    thmitll_jtl_chain #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .a(a2), .err_clr(err_clr),
        .q(q2), .err(err2), .viol_cnt(vc2)
    );

    // Checking disabled, short delay
    thmitll_jtl_chain #(.CT(1), .DELAY(2)) u_dut3 (
        .clk(clk), .rst(rst), .a(a3), .err_clr(err_clr),
        .q(q3), .err(err3), .viol_cnt(vc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past edge n
    task automatic adv(input int n);
        while (e < n) begin
            @(posedge clk);
            #1;
            e = e + 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        e   = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a0 = 4'b1010; a1 = 4'b0110; a2 = 4'b1111; a3 = 4'b0001;
        do_reset();
        tests_run++;
        if (q0 !== 4'b0000) begin tests_failed++; $display("FAIL reset_q0: got %b want 0000", q0); end
        tests_run++;
        if (err0 !== 4'b0000) begin tests_failed++; $display("FAIL reset_err0: got %b want 0000", err0); end
        tests_run++;
        if (vc0 !== 8'd0) begin tests_failed++; $display("FAIL reset_vc0: got %0d want 0", vc0); end
        tests_run++;
        if (q1 !== 4'b0000) begin tests_failed++; $display("FAIL reset_q1: got %b want 0000", q1); end
        tests_run++;
        if (vc2 !== 2'd0) begin tests_failed++; $display("FAIL reset_vc2: got %0d want 0", vc2); end
        // Nonzero a at release must not create events
        adv(12);
        tests_run++;
        if (q0 !== 4'b0000) begin tests_failed++; $display("FAIL reset_no_spurious_q0: got %b want 0000", q0); end
    endtask

    task automatic test_single();
        a0 = 4'b0000;
        do_reset();
        adv(9);  a0[0] = ~a0[0];
        adv(13);
        tests_run++;
        if (q0 !== 4'b0000) begin tests_failed++; $display("FAIL single_q_e13: got %b want 0000", q0); end
        adv(14);
        tests_run++;
        if (q0 !== 4'b0001) begin tests_failed++; $display("FAIL single_q_e14: got %b want 0001", q0); end
        tests_run++;
        if (err0 !== 4'b0000) begin tests_failed++; $display("FAIL single_err: got %b want 0000", err0); end
        adv(20);
        tests_run++;
        if (q0 !== 4'b0001) begin tests_failed++; $display("FAIL single_one_toggle: got %b want 0001", q0); end
    endtask

    task automatic test_violation();
        a0 = 4'b0000;
        do_reset();
        adv(9);  a0[1] = ~a0[1];
        adv(12); a0[1] = ~a0[1];
        adv(13);
        tests_run++;
        if (err0 !== 4'b0010) begin tests_failed++; $display("FAIL viol_err_e13: got %b want 0010", err0); end
        tests_run++;
        if (vc0 !== 8'd1) begin tests_failed++; $display("FAIL viol_cnt_e13: got %0d want 1", vc0); end
        adv(14); a0[1] = ~a0[1];
        tests_run++;
        if (q0 !== 4'b0010) begin tests_failed++; $display("FAIL viol_q_e14: got %b want 0010", q0); end
        adv(18);
        tests_run++;
        if (q0 !== 4'b0010) begin tests_failed++; $display("FAIL viol_dropped_e18: got %b want 0010", q0); end
        adv(19);
        tests_run++;
        if (q0 !== 4'b0000) begin tests_failed++; $display("FAIL viol_accept_q_e19: got %b want 0000", q0); end
        tests_run++;
        if (vc0 !== 8'd1) begin tests_failed++; $display("FAIL viol_cnt_e19: got %0d want 1", vc0); end
    endtask

    task automatic test_freeze();
        a1 = 4'b0000;
        do_reset();
        adv(9);  a1[2] = ~a1[2];
        adv(11); a1[2] = ~a1[2];
        adv(12);
        tests_run++;
        if (err1 !== 4'b0100) begin tests_failed++; $display("FAIL freeze_err_e12: got %b want 0100", err1); end
        adv(14);
        tests_run++;
        if (q1 !== 4'b0000) begin tests_failed++; $display("FAIL freeze_flushed_e14: got %b want 0000", q1); end
        adv(19); a1[2] = ~a1[2];
        adv(21); err_clr = 1'b1;
        tests_run++;
        if (vc1 !== 8'd1) begin tests_failed++; $display("FAIL freeze_ignored_cnt: got %0d want 1", vc1); end
        adv(22); err_clr = 1'b0;
        tests_run++;
        if (err1 !== 4'b0000) begin tests_failed++; $display("FAIL freeze_clr_err: got %b want 0000", err1); end
        tests_run++;
        if (vc1 !== 8'd0) begin tests_failed++; $display("FAIL freeze_clr_cnt: got %0d want 0", vc1); end
        adv(24); a1[2] = ~a1[2];
        tests_run++;
        if (q1 !== 4'b0000) begin tests_failed++; $display("FAIL freeze_frozen_q_e24: got %b want 0000", q1); end
        adv(28);
        tests_run++;
        if (q1 !== 4'b0000) begin tests_failed++; $display("FAIL freeze_q_e28: got %b want 0000", q1); end
        adv(29);
        tests_run++;
        if (q1 !== 4'b0100) begin tests_failed++; $display("FAIL freeze_resume_q_e29: got %b want 0100", q1); end
    endtask

    task automatic test_saturate();
        a2 = 4'b0000;
        do_reset();
        adv(9);  a2 = ~a2;
        adv(10); a2 = ~a2;
        adv(11);
        tests_run++;
        if (vc2 !== 2'd3) begin tests_failed++; $display("FAIL sat_cnt_e11: got %0d want 3", vc2); end
        tests_run++;
        if (err2 !== 4'b1111) begin tests_failed++; $display("FAIL sat_err_e11: got %b want 1111", err2); end
        adv(12); a2[1:0] = ~a2[1:0]; err_clr = 1'b1;
        tests_run++;
        if (vc2 !== 2'd3) begin tests_failed++; $display("FAIL sat_hold_e12: got %0d want 3", vc2); end
        adv(13); err_clr = 1'b0;
        tests_run++;
        if (vc2 !== 2'd2) begin tests_failed++; $display("FAIL sat_clr_cnt_e13: got %0d want 2", vc2); end
        tests_run++;
        if (err2 !== 4'b0011) begin tests_failed++; $display("FAIL sat_clr_err_e13: got %b want 0011", err2); end
        adv(14);
        tests_run++;
        if (q2 !== 4'b1111) begin tests_failed++; $display("FAIL sat_q_e14: got %b want 1111", q2); end
    endtask

    task automatic test_back_to_back();
        a3 = 4'b0000;
        do_reset();
        adv(9);  a3[0] = ~a3[0];
        adv(10); a3[0] = ~a3[0];
        adv(11); a3[0] = ~a3[0];
        tests_run++;
        if (q3 !== 4'b0000) begin tests_failed++; $display("FAIL b2b_q_e11: got %b want 0000", q3); end
        adv(12);
        tests_run++;
        if (q3 !== 4'b0001) begin tests_failed++; $display("FAIL b2b_q_e12: got %b want 0001", q3); end
        adv(13);
        tests_run++;
        if (q3 !== 4'b0000) begin tests_failed++; $display("FAIL b2b_q_e13: got %b want 0000", q3); end
        adv(14);
        tests_run++;
        if (q3 !== 4'b0001) begin tests_failed++; $display("FAIL b2b_q_e14: got %b want 0001", q3); end
        tests_run++;
        if (err3 !== 4'b0000 || vc3 !== 8'd0) begin
            tests_failed++;
            $display("FAIL b2b_no_viol: got err=%b cnt=%0d want err=0000 cnt=0", err3, vc3);
        end
    endtask

    task automatic test_startup_reset();
        a0 = 4'b0000;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a0[3] = ~a0[3];
            @(posedge clk);
            #1;
        end
        e   = 0;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            a0[3] = ~a0[3];
            adv(k);
        end
        adv(9);
        tests_run++;
        if (q0 !== 4'b0000) begin tests_failed++; $display("FAIL startup_q: got %b want 0000", q0); end
        tests_run++;
        if (err0 !== 4'b0000 || vc0 !== 8'd0) begin
            tests_failed++;
            $display("FAIL startup_err: got err=%b cnt=%0d want err=0000 cnt=0", err0, vc0);
        end
        a0[3] = ~a0[3];
        adv(11); rst = 1'b1;
        adv(12); rst = 1'b0;
        adv(20);
        tests_run++;
        if (q0 !== 4'b0000) begin tests_failed++; $display("FAIL rst_discard_q: got %b want 0000", q0); end
        tests_run++;
        if (err0 !== 4'b0000) begin tests_failed++; $display("FAIL rst_discard_err: got %b want 0000", err0); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        e            = 0;
        rst          = 1'b1;
        err_clr      = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        test_reset();
        test_single();
        test_violation();
        test_freeze();
        test_saturate();
        test_back_to_back();
        test_startup_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/thmitll_jtl_chain.md
THMITLL_JTL_CHAIN -- requirements
Module: thmitll_jtl_chain

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent pulse channels, 1..32.
REQ-002 SHALL have parameter DELAY, default 4: input-event-to-output-toggle latency in clk cycles, 1..64.
REQ-003 SHALL have parameter CT, default 5: critical-timing window in cycles, 1..64; CT=1 disables checking.
REQ-004 SHALL have parameter STARTUP, default 4: cycles after reset release during which input events are ignored.
REQ-005 SHALL have parameter FREEZE, default 0: 0 = drop violating pulse only; 1 = drop it and freeze the channel.
REQ-006 SHALL have parameter CNT_W, default 8: width of the violation counter.
REQ-007 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-008 Port: rst  input  1  reset; synchronous, active-high.
REQ-009 Port: a  input  CHANNELS  pulse inputs; each level change (either edge) is one pulse event.
REQ-010 Port: err_clr  input  1  clears err, viol_cnt and freeze state.
REQ-011 Port: q  output  CHANNELS  pulse outputs; each toggle is one propagated pulse.
REQ-012 Port: err  output  CHANNELS  sticky per-channel critical-timing violation flag.
REQ-013 Port: viol_cnt  output  CNT_W  saturating count of violations, all channels.

Function
REQ-014 SHALL register a every cycle into a_d; event e[i] = a[i] XOR a_d[i], evaluated at each edge.
REQ-015 SHALL ignore all events while the startup counter is nonzero; a_d still tracks a.
REQ-016 SHALL keep, per channel, a window counter wc, loaded with CT-1 on an accepted event and decremented each cycle while nonzero.
REQ-017 An event with wc=0 and channel not frozen SHALL be accepted; an event with wc!=0 SHALL be a violation.
REQ-018 An accepted event detected at edge k SHALL toggle q[i] so the new value is visible after edge k+DELAY; exactly one toggle per accepted event.
REQ-019 Accepted events SHALL be pipelined so back-to-back accepted events (CT=1) each emerge DELAY cycles later, with no loss.
REQ-020 A violation SHALL NOT propagate, SHALL NOT reload wc, SHALL set err[i] at the next edge.
REQ-021 With FREEZE=1, a violation SHALL flush channel i's in-flight pulses (q[i] held at current value) and ignore further events until err_clr or rst.
REQ-022 viol_cnt SHALL add the number of channels violating in a cycle, saturating at 2^CNT_W-1.
REQ-023 Simultaneous violation and err_clr: clear applies first, then the new violation sets err and counts (viol_cnt = number violating that cycle).
REQ-024 Channels SHALL be fully independent except for the shared viol_cnt.

Reset
REQ-025 On rst: q=0, err=0, viol_cnt=0, wc=0, pipelines empty, freeze cleared, startup counter=STARTUP, a_d loaded from a (no spurious event on release).
REQ-026 rst asserted mid-operation SHALL discard all in-flight pulses; no q toggle occurs after the reset edge.

Structure
REQ-027 Package jtl_pkg SHALL hold parameter defaults, limits and the FREEZE mode constants (MODE_DROP=0, MODE_FREEZE=1).
REQ-028 Per-channel logic (edge detect, wc, delay pipe, freeze, err) SHALL be sub-module jtl_chan, instantiated CHANNELS times; top holds startup counter and viol_cnt adder.

Verification
REQ-029 Defaults; after startup, toggle a[0] at edge 10 -> q[0] toggles after edge 14; other q unchanged; err=0.
REQ-030 Defaults; a[1] events at edges 10 and 13 -> one q[1] toggle after edge 14, err[1]=1 after edge 13, viol_cnt=1; event at edge 15 accepted, q[1] toggles after edge 19.
REQ-031 FREEZE=1; a[2] events at 10,12,20 -> no q[2] toggle from any event (10's flushed at 12), err[2]=1; err_clr at 22, event at 25 -> q[2] toggles after 29.
REQ-032 CNT_W=2; violations on all 4 channels in one cycle -> viol_cnt=3 (saturated); err_clr same cycle as 2 new violations -> viol_cnt=2.
REQ-033 a[3] toggles during reset and startup cycles -> no q toggle; rst pulse at edge 12 with event accepted at 10 -> q[3] stays 0.
